// File: rtl/imem_loader.sv
// Byte-stream boot loader: parses a framed, XOR-checksummed image and writes it
// word by word into instruction memory, holding the core in reset until it is valid.
module imem_loader #(
  parameter int         DATA_WIDTH  = 32,
  parameter int         DEPTH_WORDS = 1024,
  parameter logic [7:0] SYNC_BYTE   = 8'hA5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  output logic                  in_ready,
  output logic                  imem_we,
  output logic [DATA_WIDTH-1:0] imem_waddr,
  output logic [DATA_WIDTH-1:0] imem_wdata,
  output logic                  cpu_rst,
  output logic                  done,
  output logic                  err
);

  localparam int BYTES  = DATA_WIDTH / 8;
  localparam int BSEL_W = $clog2(BYTES);
  localparam int IDX_W  = 16;
  localparam logic [16:0]       DEPTH_LIM = 17'(DEPTH_WORDS);
  localparam logic [BSEL_W-1:0] LAST_BYTE = BSEL_W'(BYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN0, S_LEN1, S_DATA, S_WRITE, S_CSUM, S_DONE, S_ERR
  } state_t;

  state_t                state_q, state_d;
  logic [IDX_W-1:0]      len_q, len_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [BSEL_W-1:0]     bsel_q, bsel_d;
  logic [7:0]            xor_q, xor_d;
  logic [DATA_WIDTH-1:0] word_q, word_d;
  logic [DATA_WIDTH-1:0] waddr_q, waddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

  logic                  accept;
  logic [16:0]           len_new;
  logic [DATA_WIDTH-1:0] word_ins;

  // All handshake/status outputs are pure decodes of the registered state.
  assign in_ready   = (state_q != S_WRITE);
  assign imem_we    = (state_q == S_WRITE);
  assign cpu_rst    = (state_q != S_DONE);
  assign done       = (state_q == S_DONE);
  assign err        = (state_q == S_ERR);
  assign imem_waddr = waddr_q;
  assign imem_wdata = wdata_q;

  assign accept  = in_valid && in_ready;
  assign len_new = {1'b0, in_data, len_q[7:0]};

  always_comb begin
    word_ins = word_q;
    for (int b = 0; b < BYTES; b++) begin
      if (bsel_q == BSEL_W'(b)) word_ins[8*b +: 8] = in_data;
    end
  end

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    idx_d   = idx_q;
    bsel_d  = bsel_q;
    xor_d   = xor_q;
    word_d  = word_q;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (accept && in_data == SYNC_BYTE) begin
          state_d = S_LEN0;
          idx_d   = '0;
          bsel_d  = '0;
          xor_d   = '0;
        end
      end
      S_LEN0: begin
        if (accept) begin
          len_d[7:0] = in_data;
          state_d    = S_LEN1;
        end
      end
      S_LEN1: begin
        if (accept) begin
          len_d = len_new[IDX_W-1:0];
          if (len_new > DEPTH_LIM)   state_d = S_ERR;
          else if (len_new == 17'd0) state_d = S_CSUM;
          else                       state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (accept) begin
          word_d = word_ins;
          xor_d  = xor_q ^ in_data;
          bsel_d = bsel_q + 1'b1;
          if (bsel_q == LAST_BYTE) begin
            // Latch the write beat now so WRITE presents registered values.
            state_d = S_WRITE;
            wdata_d = word_ins;
            waddr_d = {{(DATA_WIDTH-IDX_W-BSEL_W){1'b0}}, idx_q, {BSEL_W{1'b0}}};
          end
        end
      end
      S_WRITE: begin
        idx_d   = idx_q + 1'b1;
        state_d = (idx_q + 1'b1 == len_q) ? S_CSUM : S_DATA;
      end
      S_CSUM: begin
        if (accept) state_d = (in_data == xor_q) ? S_DONE : S_ERR;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      idx_q   <= '0;
      bsel_q  <= '0;
      xor_q   <= '0;
      word_q  <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      bsel_q  <= bsel_d;
      xor_q   <= xor_d;
      word_q  <= word_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: a byte-level frame model predicts writes and
// final status; a per-cycle monitor checks every write strobe against it.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready, imem_we, cpu_rst, done, err;
  logic [31:0] imem_waddr, imem_wdata;

  int checks = 0;
  int errors = 0;
  int writes_seen = 0;
  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_data_q[$];

  localparam int OUT_NONE = 0;
  localparam int OUT_DONE = 1;
  localparam int OUT_ERR  = 2;

  imem_loader #(.DATA_WIDTH(32), .DEPTH_WORDS(1024), .SYNC_BYTE(8'hA5)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .imem_we(imem_we), .imem_waddr(imem_waddr),
    .imem_wdata(imem_wdata), .cpu_rst(cpu_rst), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired before end of test");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  // Frame model: skip to the first sync byte, then decode length, little-endian
  // words and the payload XOR exactly as the frame format defines them.
  task automatic model(input logic [7:0] bs[$], output int outcome);
    int i, n, p;
    logic [7:0] x;
    outcome = OUT_NONE;
    i = 0;
    while (i < bs.size() && bs[i] != 8'hA5) i++;
    if (i + 2 >= bs.size()) return;
    n = int'({bs[i+2], bs[i+1]});
    if (n > 1024) begin
      outcome = OUT_ERR;
      return;
    end
    x = 8'h00;
    for (int w = 0; w < n; w++) begin
      p = i + 3 + 4*w;
      exp_addr_q.push_back(32'(4*w));
      exp_data_q.push_back({bs[p+3], bs[p+2], bs[p+1], bs[p]});
      x = x ^ bs[p] ^ bs[p+1] ^ bs[p+2] ^ bs[p+3];
    end
    outcome = (bs[i+3+4*n] == x) ? OUT_DONE : OUT_ERR;
  endtask

  task automatic send(input logic [7:0] bs[$], input int gap);
    logic rdy;
    int   n;
    foreach (bs[k]) begin
      in_valid = 1'b1;
      in_data  = bs[k];
      n = 0;
      do begin
        @(negedge clk);
        rdy = in_ready;
        @(posedge clk);
        #1;
        n++;
      end while (!rdy && n < 20);
      if (!rdy) chk("accept_timeout", 32'(rdy), 32'd1);
      if (gap > 0) begin
        in_valid = 1'b0;
        repeat (gap) begin
          @(posedge clk);
          #1;
        end
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic finish_frame(input string name, input int outcome, input int want_writes);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    chk({name, "_done"}, 32'(done), 32'(outcome == OUT_DONE));
    chk({name, "_err"}, 32'(err), 32'(outcome == OUT_ERR));
    chk({name, "_cpu_rst"}, 32'(cpu_rst), 32'(outcome != OUT_DONE));
    chk({name, "_pending"}, 32'(exp_addr_q.size()), 32'd0);
    chk({name, "_nwrites"}, 32'(writes_seen), 32'(want_writes));
    $display("frame %s done=%0b err=%0b cpu_rst=%0b writes=%0d", name, done, err, cpu_rst, writes_seen);
  endtask

  task automatic check_reset_values(input string name);
    chk({name, "_in_ready"}, 32'(in_ready), 32'd1);
    chk({name, "_imem_we"}, 32'(imem_we), 32'd0);
    chk({name, "_waddr"}, imem_waddr, 32'h0);
    chk({name, "_wdata"}, imem_wdata, 32'h0);
    chk({name, "_cpu_rst"}, 32'(cpu_rst), 32'd1);
    chk({name, "_done"}, 32'(done), 32'd0);
    chk({name, "_err"}, 32'(err), 32'd0);
  endtask

  initial begin
    logic [7:0] f[$];
    logic [7:0] g[$];
    int outcome;

    fork
      forever begin
        @(negedge clk);
        chk("ready_vs_we", 32'(in_ready), 32'(!imem_we));
        if (imem_we) begin
          writes_seen++;
          chk("write_expected", 32'(exp_addr_q.size() != 0), 32'd1);
          if (exp_addr_q.size() != 0) begin
            chk("waddr", imem_waddr, exp_addr_q.pop_front());
            chk("wdata", imem_wdata, exp_data_q.pop_front());
          end
          $display("write addr=%h data=%h", imem_waddr, imem_wdata);
        end
      end
    join_none

    #1;
    check_reset_values("reset");
    repeat (3) @(posedge clk);
    #3 rst = 1'b1;
    @(posedge clk);
    #1;

    // Two-word program; payload XOR is 0x70.
    writes_seen = 0;
    f = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h05, 8'h50, 8'h00, 8'h93, 8'h05, 8'hA0, 8'h00, 8'h70};
    model(f, outcome);
    chk("model_prog_w0", exp_data_q[0], 32'h00500513);
    chk("model_prog_w1", exp_data_q[1], 32'h00A00593);
    chk("model_prog_out", 32'(outcome), 32'(OUT_DONE));
    send(f, 0);
    finish_frame("prog", outcome, 2);

    // Leading junk, one word, bad checksum.
    writes_seen = 0;
    f = '{8'h00, 8'hFF, 8'hA5, 8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h00};
    model(f, outcome);
    chk("model_bad_w0", exp_data_q[0], 32'h44332211);
    chk("model_bad_out", 32'(outcome), 32'(OUT_ERR));
    send(f, 1);
    finish_frame("badcsum", outcome, 1);

    // N = 1025 exceeds capacity.
    writes_seen = 0;
    f = '{8'hA5, 8'h01, 8'h04};
    model(f, outcome);
    send(f, 0);
    finish_frame("toolong", outcome, 0);

    // Empty image, then a reload whose payload is all sync bytes.
    writes_seen = 0;
    f = '{8'hA5, 8'h00, 8'h00, 8'h00};
    model(f, outcome);
    send(f, 2);
    finish_frame("empty", outcome, 0);

    writes_seen = 0;
    f = '{8'hA5, 8'h01, 8'h00, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'h00};
    model(f, outcome);
    chk("model_sync_w0", exp_data_q[0], 32'hA5A5A5A5);
    g = '{8'hA5};
    send(g, 0);
    chk("reload_cpu_rst", 32'(cpu_rst), 32'd1);
    chk("reload_done_clr", 32'(done), 32'd0);
    g = '{8'h01, 8'h00, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'h00};
    send(g, 0);
    finish_frame("syncdata", outcome, 1);

    // Abort an N=2 frame after 6 payload bytes with an asynchronous reset.
    writes_seen = 0;
    exp_addr_q.push_back(32'h0);
    exp_data_q.push_back(32'h04030201);
    f = '{8'hA5, 8'h02, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    send(f, 0);
    #2 rst = 1'b0;
    #1;
    check_reset_values("abort");
    chk("abort_pending", 32'(exp_addr_q.size()), 32'd0);
    chk("abort_nwrites", 32'(writes_seen), 32'd1);
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    @(posedge clk);
    #1;

    writes_seen = 0;
    f = '{8'h00, 8'hA5, 8'h02, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22, 8'h33, 8'h44, 8'h44};
    model(f, outcome);
    chk("model_fresh_w0", exp_data_q[0], 32'hDDCCBBAA);
    chk("model_fresh_a1", exp_addr_q[1], 32'h4);
    send(f, 2);
    finish_frame("fresh", outcome, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
